proto_clone_server: RTL and testbench

- Hardware analogue of the prototype-family pattern, for the consumer side.
- A loader installs per-id prototype templates. Requesters ask for a clone by id.
- The block snapshots the template and streams a serialized copy, with a unique clone serial, over a valid/ready output.
- Sits between the template-programming path and any downstream object consumer.

---
 rtl/proto_clone_server.sv | 111 +++++++++++
 tb/tb_proto_clone_server.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/proto_clone_server.sv
// Prototype clone server: per-id template store plus a snapshot-and-stream engine
// that emits a serialized copy of a template, tagged with a unique clone serial.
//   state  | meaning
//   IDLE   | waiting for a clone request, req_ready high
//   STREAM | emitting snapshot words, one per accepted beat
//   ERR    | single error beat for a request naming an uninstalled slot
module proto_clone_server #(
  parameter int NUM_PROTO = 8,
  parameter int WORDS     = 4,
  parameter int DW        = 32,
  parameter int SW        = 16,
  localparam int IW = (NUM_PROTO > 1) ? $clog2(NUM_PROTO) : 1,
  localparam int XW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  input  logic [IW-1:0]        ld_id,
  input  logic [XW-1:0]        ld_word,
  input  logic [DW-1:0]        ld_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IW-1:0]        req_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  output logic                 out_err,
  output logic [IW-1:0]        out_id,
  output logic [SW-1:0]        out_serial,
  output logic [NUM_PROTO-1:0] installed
);

  typedef enum logic [1:0] {IDLE, STREAM, ERR} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] tmpl [NUM_PROTO][WORDS];
  logic [DW-1:0] snap [WORDS];
  logic [XW-1:0] beat;
  logic [IW-1:0] id_q;
  logic [SW-1:0] serial_q;
  logic [SW-1:0] counter;
  logic          ld_ok;
  logic          req_hit;
  logic          last_beat;

  assign ld_ok     = ld_valid && (int'(ld_word) < WORDS) && (int'(ld_id) < NUM_PROTO);
  assign req_hit   = (int'(req_id) < NUM_PROTO) && installed[req_id];
  assign last_beat = (beat == XW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PROTO; p++)
        for (int w = 0; w < WORDS; w++)
          tmpl[p][w] <= '0;
      installed <= '0;
    end else if (ld_ok) begin
      tmpl[ld_id][ld_word] <= ld_data;
      if (int'(ld_word) == WORDS - 1)
        installed[ld_id] <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_hit ? STREAM : ERR;
      STREAM:  if (out_ready && last_beat) state_nxt = IDLE;
      ERR:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot uses pre-edge template contents, so a same-cycle load never leaks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      for (int w = 0; w < WORDS; w++)
        snap[w] <= '0;
      beat     <= '0;
      id_q     <= '0;
      serial_q <= '0;
      counter  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        id_q <= req_id;
        beat <= '0;
        if (req_hit) begin
          for (int w = 0; w < WORDS; w++)
            snap[w] <= tmpl[req_id][w];
          serial_q <= counter;
          counter  <= counter + SW'(1);
        end
      end else if (state == STREAM && out_ready && !last_beat) begin
        beat <= beat + XW'(1);
      end
    end
  end

  always_comb begin
    req_ready  = rst_n && (state == IDLE);
    out_valid  = (state != IDLE);
    out_err    = (state == ERR);
    out_last   = (state == ERR) || (state == STREAM && last_beat);
    out_data   = (state == STREAM) ? snap[beat] : '0;
    out_serial = (state == STREAM) ? serial_q : '0;
    out_id     = (state != IDLE) ? id_q : '0;
  end

endmodule

// File: tb/tb_proto_clone_server.sv
// Directed bench for proto_clone_server: a table of clone requests checked beat by
// beat against a template model, plus hand-written reset-abort sequence.
module tb_proto_clone_server;
  localparam int NP = 8;
  localparam int W  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int IW = 3;
  localparam int XW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic [IW-1:0] ld_id = '0;
  logic [XW-1:0] ld_word = '0;
  logic [DW-1:0] ld_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_id = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_err;
  logic [IW-1:0] out_id;
  logic [SW-1:0] out_serial;
  logic [NP-1:0] installed;

  proto_clone_server #(.NUM_PROTO(NP), .WORDS(W), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_id(ld_id), .ld_word(ld_word), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .out_id(out_id),
    .out_serial(out_serial), .installed(installed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] tmem [NP][W];

  // mode: 0 none, 1 load in the request cycle, 2 load during the second stream cycle
  typedef struct {
    int          id;
    int          mode;
    int          lid;
    int          lword;
    logic [31:0] ldat;
    bit          stall;
    bit          err;
    int          serial;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int id, input int w, input logic [31:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_id = IW'(id); ld_word = XW'(w); ld_data = d;
    tmem[id][w] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic run_clone(input vec_t v);
    logic [DW-1:0] exp [W];
    int  nb, beat, cyc;
    bit  acc;
    for (int w = 0; w < W; w++) exp[w] = v.err ? '0 : tmem[v.id][w];
    nb = v.err ? 1 : W;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_id = IW'(v.id);
    ld_id = IW'(v.lid); ld_word = XW'(v.lword); ld_data = v.ldat;
    ld_valid = (v.mode == 1);
    if (v.mode == 1) tmem[v.lid][v.lword] = v.ldat;
    @(negedge clk);
    req_valid = 1'b0; ld_valid = 1'b0;
    beat = 0; cyc = 0;
    while (beat < nb && cyc < 40) begin
      out_ready = v.stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      ld_valid = (v.mode == 2 && cyc == 1);
      if (v.mode == 2 && cyc == 1) tmem[v.lid][v.lword] = v.ldat;
      chk("out_valid", 64'(out_valid), 64'(1));
      chk("out_err", 64'(out_err), 64'(v.err));
      chk("out_last", 64'(out_last), 64'(beat == nb - 1));
      chk("out_data", 64'(out_data), 64'(exp[beat]));
      chk("out_serial", 64'(out_serial), v.err ? 64'(0) : 64'(v.serial));
      chk("out_id", 64'(out_id), 64'(v.id));
      chk("req_ready_busy", 64'(req_ready), 64'(0));
      @(posedge clk);
      acc = out_ready;
      @(negedge clk);
      ld_valid = 1'b0;
      if (acc) beat++;
      cyc++;
    end
    chk("beats_done", 64'(beat), 64'(nb));
    chk("valid_after_last", 64'(out_valid), 64'(0));
  endtask

  initial begin
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < W; w++)
        tmem[p][w] = '0;

    vecs[0] = '{3, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0};
    vecs[1] = '{5, 0, 0, 0, 32'h0, 1'b0, 1'b1, 0};
    vecs[2] = '{3, 0, 0, 0, 32'h0, 1'b1, 1'b0, 1};
    vecs[3] = '{3, 2, 3, 2, 32'hFF, 1'b0, 1'b0, 2};
    vecs[4] = '{3, 0, 0, 0, 32'h0, 1'b0, 1'b0, 3};
    vecs[5] = '{1, 1, 1, 3, 32'h1111_0003, 1'b0, 1'b1, 0};
    vecs[6] = '{1, 0, 0, 0, 32'h0, 1'b1, 1'b0, 0};
    vecs[7] = '{6, 0, 0, 0, 32'h0, 1'b0, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));
    chk("post_rst_installed", 64'(installed), 64'(0));
    chk("post_rst_out_data", 64'(out_data), 64'(0));

    for (int w = 0; w < W; w++) load(3, w, 32'hA0 + w);
    for (int w = 0; w < 3; w++) load(1, w, 32'h1111_0000 + w);
    for (int w = 0; w < W; w++) load(6, w, 32'h6666_0000 + w);
    chk("installed_setup", 64'(installed), 64'(8'b0100_1000));

    for (int i = 0; i < 8; i++) run_clone(vecs[i]);
    chk("installed_after", 64'(installed), 64'(8'b0100_1010));

    // Reset while beat 2 of a slot-6 clone is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_id = IW'(6); out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_data", 64'(out_data), 64'(32'h6666_0002));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_installed", 64'(installed), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int w = 0; w < W; w++)
        tmem[p][w] = '0;
    @(negedge clk);
    chk("reabort_req_ready", 64'(req_ready), 64'(1));
    run_clone('{3, 0, 0, 0, 32'h0, 1'b0, 1'b1, 0});
    for (int w = 0; w < W; w++) load(2, w, 32'h2222_0000 + w);
    run_clone('{2, 0, 0, 0, 32'h0, 1'b0, 1'b0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
